// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CU memory responder: state codes, error bit
// positions, default bus widths and the address range helper.
package mem_responder_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int ERR_RW_BOTH = 0;
   localparam int ERR_RANGE   = 1;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_e;

   function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
      return (addr < depth);
   endfunction

endpackage

// File: rtl/mem_responder_array.sv
// DEPTH x DATA_W storage with one synchronous write port and one asynchronous
// read port; callers only present in-range addresses.
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_r [DEPTH];

   // Storage write; contents intentionally survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr[IDX_W-1:0]] <= wdata;
      end
   end

   assign rdata = mem_r[raddr[IDX_W-1:0]];

endmodule

// File: rtl/mem_responder.sv
// RAM-side responder for the control unit: stalls the CU through enable for
// WAIT_STATES cycles per access, and offers a preload port while the CU is idle.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addressbus,
   input  logic              read,
   input  logic              write,
   input  logic [DATA_W-1:0] toram,
   output logic [DATA_W-1:0] fromram,
   output logic              enable,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic [1:0]        err
);

   localparam logic [3:0] WS_C = 4'(WAIT_STATES);

   logic [1:0]        state_r, state_nxt_s;
   logic [3:0]        cnt_r;
   op_e               op_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r, rdata_r;
   logic [1:0]        err_r;

   logic              req_s, cu_range_s, load_range_s, acc_range_s;
   op_e               cu_op_s, acc_op_s;
   logic [ADDR_W-1:0] acc_addr_s, mem_waddr_s;
   logic [DATA_W-1:0] acc_data_s, mem_wdata_s, mem_rdata_s;
   logic              live_fire_s, wait_fire_s, fire_s;
   logic              cu_we_s, load_we_s, rd_fire_s;

   assign req_s        = read | write;
   assign cu_range_s   = addr_ok(32'(addressbus), 32'(DEPTH));
   assign load_range_s = addr_ok(32'(load_addr), 32'(DEPTH));
   assign acc_range_s  = addr_ok(32'(acc_addr_s), 32'(DEPTH));

   // Decode the CU strobes; both high means no array access at all.
   always_comb begin
      if (read && !write) begin
         cu_op_s = OP_READ;
      end else if (write && !read) begin
         cu_op_s = OP_WRITE;
      end else begin
         cu_op_s = OP_NONE;
      end
   end

   // Access source: live CU bus when acting in IDLE, latched copy in WAIT.
   always_comb begin
      if (state_r == ST_WAIT) begin
         acc_op_s   = op_r;
         acc_addr_s = addr_r;
         acc_data_s = wdata_r;
      end else begin
         acc_op_s   = cu_op_s;
         acc_addr_s = addressbus;
         acc_data_s = toram;
      end
   end

   // With 0 or 1 wait states the access happens on the edge that sees the request.
   assign live_fire_s = (state_r == ST_IDLE) && req_s && (WAIT_STATES <= 1);
   assign wait_fire_s = (state_r == ST_WAIT) && (cnt_r <= 4'd1);
   assign fire_s      = live_fire_s | wait_fire_s;
   assign cu_we_s     = fire_s && (acc_op_s == OP_WRITE) && acc_range_s;
   assign rd_fire_s   = fire_s && (acc_op_s == OP_READ);

   assign load_ready  = (state_r == ST_IDLE) && !req_s && load_en;
   assign load_we_s   = load_ready && load_range_s;

   // Write port mux; CU and preload are mutually exclusive by construction.
   always_comb begin
      if (cu_we_s) begin
         mem_waddr_s = acc_addr_s;
         mem_wdata_s = acc_data_s;
      end else begin
         mem_waddr_s = load_addr;
         mem_wdata_s = load_data;
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (cu_we_s | load_we_s),
      .waddr (mem_waddr_s),
      .wdata (mem_wdata_s),
      .raddr (acc_addr_s),
      .rdata (mem_rdata_s)
   );

   // Handshake next state and CU stall line.
   always_comb begin
      state_nxt_s = state_r;
      enable      = 1'b1;
      case (state_r)
         ST_IDLE: begin
            if (req_s && (WAIT_STATES > 0)) begin
               enable      = 1'b0;
               state_nxt_s = (WAIT_STATES > 1) ? ST_WAIT : ST_DONE;
            end else begin
               enable      = 1'b1;
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            enable      = 1'b0;
            state_nxt_s = (cnt_r <= 4'd1) ? ST_DONE : ST_WAIT;
         end
         ST_DONE: begin
            enable      = 1'b1;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            enable      = 1'b1;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Zero-wait reads bypass the data register; otherwise the register drives the bus.
   always_comb begin
      if ((WAIT_STATES == 0) && (state_r == ST_IDLE) && (cu_op_s == OP_READ)) begin
         fromram = cu_range_s ? mem_rdata_s : {DATA_W{1'b0}};
      end else begin
         fromram = rdata_r;
      end
   end

   assign err = err_r;

   // FSM, wait counter, request latch, read data and sticky error flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         op_r    <= OP_NONE;
         addr_r  <= {ADDR_W{1'b0}};
         wdata_r <= {DATA_W{1'b0}};
         rdata_r <= {DATA_W{1'b0}};
         err_r   <= 2'b00;
      end else begin
         state_r <= state_nxt_s;
         if ((state_r == ST_IDLE) && req_s) begin
            cnt_r   <= WS_C - 4'd1;
            op_r    <= cu_op_s;
            addr_r  <= addressbus;
            wdata_r <= toram;
         end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
         end else begin
            cnt_r <= cnt_r;
         end
         if (rd_fire_s) begin
            rdata_r <= acc_range_s ? mem_rdata_s : {DATA_W{1'b0}};
         end
         if ((state_r == ST_IDLE) && read && write) begin
            err_r[ERR_RW_BOTH] <= 1'b1;
         end
         if (((state_r == ST_IDLE) && req_s && !cu_range_s) ||
             (load_ready && !load_range_s)) begin
            err_r[ERR_RANGE] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (0, 1 and 3 wait states)
// driven by a vector table and hand-written handshake sequences.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ab [3];
   logic        rd [3];
   logic        wr [3];
   logic [15:0] td [3];
   logic [15:0] fr [3];
   logic        en [3];
   logic        le [3];
   logic [7:0]  la [3];
   logic [15:0] ld [3];
   logic        lr [3];
   logic [1:0]  er [3];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst_n(rst_n), .addressbus(ab[0]), .read(rd[0]), .write(wr[0]),
      .toram(td[0]), .fromram(fr[0]), .enable(en[0]), .load_en(le[0]),
      .load_addr(la[0]), .load_data(ld[0]), .load_ready(lr[0]), .err(er[0]));

   mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
      .clk(clk), .rst_n(rst_n), .addressbus(ab[1]), .read(rd[1]), .write(wr[1]),
      .toram(td[1]), .fromram(fr[1]), .enable(en[1]), .load_en(le[1]),
      .load_addr(la[1]), .load_data(ld[1]), .load_ready(lr[1]), .err(er[1]));

   mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst_n(rst_n), .addressbus(ab[2]), .read(rd[2]), .write(wr[2]),
      .toram(td[2]), .fromram(fr[2]), .enable(en[2]), .load_en(le[2]),
      .load_addr(la[2]), .load_data(ld[2]), .load_ready(lr[2]), .err(er[2]));

   typedef struct {
      logic        r;
      logic        w;
      logic [7:0]  a;
      logic [15:0] d;
      logic        chk_d;
      logic [15:0] exp_d;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int i, input logic [7:0] a, input logic [15:0] d);
      le[i] = 1'b1;
      la[i] = a;
      ld[i] = d;
      @(negedge clk);
      chk("preload_ready", 32'(lr[i]), 32'd1);
      tick();
      le[i] = 1'b0;
   endtask

   // One CU access: hold strobes until enable is seen high, then advance.
   task automatic cu_access(input int i, input logic r, input logic w, input logic [7:0] a,
                            input logic [15:0] d, output int stalls, output logic [15:0] data);
      bit done;
      int k;
      rd[i] = r;
      wr[i] = w;
      ab[i] = a;
      td[i] = d;
      stalls = 0;
      data = 16'h0000;
      done = 1'b0;
      k = 0;
      while (!done && k < 40) begin
         @(negedge clk);
         if (en[i]) begin
            data = fr[i];
            done = 1'b1;
         end else begin
            stalls++;
         end
         k++;
      end
      if (!done) chk("access_timeout", 32'd0, 32'd1);
      tick();
      rd[i] = 1'b0;
      wr[i] = 1'b0;
   endtask

   initial begin
      vec_t        tbl [7];
      int          st;
      int          c0;
      logic [15:0] dt;

      tbl[0] = '{r: 1'b1, w: 1'b0, a: 8'd1, d: 16'h0000, chk_d: 1'b1, exp_d: 16'h0011};
      tbl[1] = '{r: 1'b1, w: 1'b0, a: 8'd2, d: 16'h0000, chk_d: 1'b1, exp_d: 16'h0022};
      tbl[2] = '{r: 1'b1, w: 1'b0, a: 8'd3, d: 16'h0000, chk_d: 1'b1, exp_d: 16'h0033};
      tbl[3] = '{r: 1'b1, w: 1'b0, a: 8'd4, d: 16'h0000, chk_d: 1'b1, exp_d: 16'h0044};
      tbl[4] = '{r: 1'b0, w: 1'b1, a: 8'd3, d: 16'h0099, chk_d: 1'b0, exp_d: 16'h0000};
      tbl[5] = '{r: 1'b1, w: 1'b0, a: 8'd3, d: 16'h0000, chk_d: 1'b1, exp_d: 16'h0099};
      tbl[6] = '{r: 1'b1, w: 1'b0, a: 8'd1, d: 16'h0000, chk_d: 1'b1, exp_d: 16'h0011};

      for (int i = 0; i < 3; i++) begin
         ab[i] = 8'd0; rd[i] = 1'b0; wr[i] = 1'b0; td[i] = 16'h0000;
         le[i] = 1'b0; la[i] = 8'd0; ld[i] = 16'h0000;
      end
      rst_n = 1'b0;
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("reset_fromram", 32'(fr[i]), 32'd0);
         chk("reset_err", 32'(er[i]), 32'd0);
         chk("reset_enable", 32'(en[i]), 32'd1);
      end
      rst_n = 1'b1;
      tick();

      // Preload every instance while its CU is idle
      preload(1, 8'd5, 16'h1234);
      preload(1, 8'd6, 16'hBEEF);
      preload(1, 8'd2, 16'h2222);
      preload(0, 8'd1, 16'h0011);
      preload(0, 8'd2, 16'h0022);
      preload(0, 8'd3, 16'h0033);
      preload(0, 8'd4, 16'h0044);
      preload(2, 8'd9, 16'h0005);

      // One wait state: read 5 then check IDLE behaviour, then read 6
      cu_access(1, 1'b1, 1'b0, 8'd5, 16'h0000, st, dt);
      chk("ws1_read5_stalls", 32'(st), 32'd1);
      chk("ws1_read5_data", 32'(dt), 32'h1234);
      @(negedge clk);
      chk("ws1_idle_enable", 32'(en[1]), 32'd1);
      chk("ws1_idle_fromram", 32'(fr[1]), 32'h1234);
      tick();
      cu_access(1, 1'b1, 1'b0, 8'd6, 16'h0000, st, dt);
      chk("ws1_read6_stalls", 32'(st), 32'd1);
      chk("ws1_read6_data", 32'(dt), 32'hBEEF);

      // Three wait states: back-to-back write then read of addr 7
      c0 = cyc;
      cu_access(2, 1'b0, 1'b1, 8'd7, 16'h00AA, st, dt);
      chk("ws3_write_stalls", 32'(st), 32'd3);
      cu_access(2, 1'b1, 1'b0, 8'd7, 16'h0000, st, dt);
      chk("ws3_read_stalls", 32'(st), 32'd3);
      chk("ws3_read_data", 32'(dt), 32'h00AA);
      chk("ws3_total_cycles", 32'(cyc - c0), 32'd8);

      // Read and write together: flag, no access, handshake still completes
      cu_access(1, 1'b1, 1'b1, 8'd2, 16'h7777, st, dt);
      chk("rw_both_stalls", 32'(st), 32'd1);
      chk("rw_both_fromram", 32'(dt), 32'hBEEF);
      @(negedge clk);
      chk("rw_both_err", 32'(er[1]), 32'd1);
      tick();
      cu_access(1, 1'b1, 1'b0, 8'd2, 16'h0000, st, dt);
      chk("rw_both_mem_kept", 32'(dt), 32'h2222);
      chk("rw_both_err_sticky", 32'(er[1]), 32'd1);

      // Zero wait states: vector table
      for (int v = 0; v < 7; v++) begin
         rd[0] = tbl[v].r;
         wr[0] = tbl[v].w;
         ab[0] = tbl[v].a;
         td[0] = tbl[v].d;
         @(negedge clk);
         chk("ws0_enable", 32'(en[0]), 32'd1);
         if (tbl[v].chk_d) chk("ws0_fromram", 32'(fr[0]), 32'(tbl[v].exp_d));
         tick();
      end
      rd[0] = 1'b0;
      wr[0] = 1'b0;

      // Out-of-range read on the 128-deep instance
      rd[0] = 1'b1;
      ab[0] = 8'd200;
      @(negedge clk);
      chk("range_fromram", 32'(fr[0]), 32'd0);
      chk("range_err_before", 32'(er[0]), 32'd0);
      tick();
      rd[0] = 1'b0;
      @(negedge clk);
      chk("range_err", 32'(er[0]), 32'd2);
      tick();

      // Preload and CU read in the same idle cycle: CU wins, load waits
      le[1] = 1'b1; la[1] = 8'd10; ld[1] = 16'h5A5A;
      rd[1] = 1'b1; ab[1] = 8'd5;
      @(negedge clk);
      chk("conflict_ready_idle", 32'(lr[1]), 32'd0);
      chk("conflict_enable_idle", 32'(en[1]), 32'd0);
      tick();
      @(negedge clk);
      chk("conflict_enable_done", 32'(en[1]), 32'd1);
      chk("conflict_fromram", 32'(fr[1]), 32'h1234);
      chk("conflict_ready_done", 32'(lr[1]), 32'd0);
      tick();
      rd[1] = 1'b0;
      @(negedge clk);
      chk("conflict_ready_after", 32'(lr[1]), 32'd1);
      tick();
      le[1] = 1'b0;
      cu_access(1, 1'b1, 1'b0, 8'd10, 16'h0000, st, dt);
      chk("conflict_load_data", 32'(dt), 32'h5A5A);

      // Reset in the middle of a write's wait states
      wr[2] = 1'b1; ab[2] = 8'd9; td[2] = 16'hFFFF;
      tick();
      @(negedge clk);
      chk("abort_in_wait", 32'(en[2]), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_fromram", 32'(fr[2]), 32'd0);
      chk("abort_err_ws1", 32'(er[1]), 32'd0);
      chk("abort_err_ws0", 32'(er[0]), 32'd0);
      chk("abort_fromram_ws1", 32'(fr[1]), 32'd0);
      wr[2] = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      cu_access(2, 1'b1, 1'b0, 8'd9, 16'h0000, st, dt);
      chk("abort_mem_kept", 32'(dt), 32'h0005);
      chk("abort_read_stalls", 32'(st), 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the control unit's RAM interface.
- Accepts the CU's registered read/write strobes, address and store data.
- Returns load/fetch data and drives the CU's `enable` line low to stall it during configurable wait states.
- Also provides a side preload port so a testbench or boot loader can fill program memory while the CU issues no requests.

Parameters:
- DATA_W, 16, width of data words (matches CU datalines).
- ADDR_W, 8, width of addressbus (matches CU adlines).
- DEPTH, 256, number of implemented words; must be ≤ 2**ADDR_W.
- WAIT_STATES, 1, extra stall cycles per access; legal range 0..15.

Ports:
- clk  in  1  rising-edge clock shared with CU.
- rst_n  in  1  asynchronous active-low reset.
- addressbus  in  ADDR_W  word address from CU.
- read  in  1  CU read strobe.
- write  in  1  CU write strobe.
- toram  in  DATA_W  store data from CU.
- fromram  out  DATA_W  read data to CU.
- enable  out  1  CU advance permission; 1 = CU may take its next state step this edge.
- load_en  in  1  preload write request.
- load_addr  in  ADDR_W  preload address.
- load_data  in  DATA_W  preload data.
- load_ready  out  1  preload accepted this edge.
- err  out  2  sticky error flags: bit0 = read and write both high, bit1 = address ≥ DEPTH.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, counter=0, rdata_q=0, err=0.
  - fromram=0.
  - Array contents are not reset.
  - A pending access is aborted; an uncommitted write is dropped.
- Definitions:
  - req = read | write.
  - The CU holds its strobes, address and data stable while enable is low.
  - Every request lasts exactly one CU state step, so any req seen in IDLE is a new request.
- States: IDLE, WAIT, DONE.
- IDLE, WAIT_STATES == 0:
  - enable=1.
  - Read: fromram = mem[addressbus], combinational.
  - Write: mem[addressbus] <= toram at this edge.
  - State stays IDLE.
- IDLE, WAIT_STATES > 0, req high:
  - enable=0, combinational from req.
  - At the edge: latch addr, op and data; counter <= WAIT_STATES-1.
  - Next state is WAIT if WAIT_STATES > 1, else DONE.
- IDLE, no req: enable=1; fromram=rdata_q.
- WAIT:
  - enable=0; counter decrements each edge.
  - On the edge where counter==1 (or entry when it is already 0): perform the array access (read into rdata_q, or commit the write), then go to DONE.
- DONE:
  - enable=1; fromram=rdata_q. The CU advances on this edge.
  - Next state is always IDLE.
- Total access latency: WAIT_STATES+1 cycles from the first cycle req is visible to the CU-advancing edge.
- A write leaves rdata_q unchanged.
- read & write both high:
  - err[0] <= 1.
  - No array access; fromram unchanged.
  - Handshake timing is unchanged, so the CU is never deadlocked.
- Address ≥ DEPTH:
  - err[1] <= 1.
  - A read returns 0; a write is dropped.
  - Timing is unchanged.
- Error flags clear only on reset.
- Preload:
  - load_ready = (state==IDLE) & ~req & load_en.
  - When accepted: mem[load_addr] <= load_data.
  - A CU request in the same cycle wins; load_ready=0 and the loader must hold its request.
  - load_addr ≥ DEPTH: the write is dropped and err[1] is set.
- An unsigned counter of width 4 suffices.

Decomposition:
- Shared package:
  - State encodings IDLE/WAIT/DONE (2-bit).
  - err bit indices ERR_RW_BOTH=0, ERR_RANGE=1.
  - Default DATA_W/ADDR_W, kept equal to the CU's datalines/adlines.
- One sub-module, mem_array:
  - DEPTH x DATA_W storage.
  - One synchronous write port, muxed between CU and preload by the parent.
  - One asynchronous read port.
- Handshake FSM, counter and error logic stay in mem_responder.

Test Plan:
- Preload: write 0x1234 to addr 5 and 0xBEEF to addr 6 with no req → load_ready=1 both cycles; an idle CU read then sees mem[5]=0x1234.
- WAIT_STATES=1, read addr 5:
  - enable=0 for exactly 1 cycle.
  - DONE cycle: enable=1, fromram=0x1234.
  - Next cycle: state IDLE.
- WAIT_STATES=3, write 0x00AA to addr 7 followed by a read of addr 7:
  - enable low 3 cycles per access.
  - The read returns 0x00AA; there are no extra stalls between accesses.
- WAIT_STATES=0 fetch/decode stream over addrs 1..4 preloaded with 0x11..0x44 → enable constantly 1; fromram tracks the address combinationally.
- Error cases:
  - read=write=1 at addr 2 → err=2'b01, mem[2] unchanged, and enable completes normally.
  - DEPTH=128, read addr 200 → fromram=0, err[1]=1.
- rst_n low while in WAIT of a write to addr 9 (old value 0x0005, data 0xFFFF):
  - Async: state IDLE, fromram=0, err=0.
  - mem[9] stays 0x0005.
- Preload/CU conflict: load_en and read asserted in the same IDLE cycle → load_ready=0, the CU read is served; the load is accepted after DONE.
